switch_press_conditioner: RTL and testbench



---
 rtl/switch_press_conditioner.sv | 146 ++++++++++++++
 tb/tb_switch_press_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_press_conditioner.sv
// Per-lane synchroniser, debouncer and sticky press latch feeding the game FSM.
// A press is held until the game consumes it on a TICK, so none are lost.
module switch_press_conditioner #(
    parameter int N_SW      = 4,
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 19
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic [N_SW-1:0] SWITCHES,
    input  logic            TICK,
    output logic [N_SW-1:0] PRESS,
    output logic [N_SW-1:0] DB_LEVEL,
    output logic            ANY_PRESS
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // INIT_* states cover the period after reset before a debounced low has been
    // seen; a high accepted there lands in INIT_HI and never raises a press.
    typedef enum logic [2:0] {
        INIT_LO,
        INIT_WAIT_HI,
        INIT_HI,
        LOW,
        WAIT_HI,
        HIGH,
        WAIT_LO
    } lane_state_t;

    logic [N_SW-1:0] sync_1;
    logic [N_SW-1:0] sync_2;
    logic [N_SW-1:0] rise_done;
    logic [N_SW-1:0] press_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= SWITCHES;
            sync_2 <= sync_1;
        end
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_lane
        lane_state_t      state_q;
        lane_state_t      state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             rise;
        logic             s;

        assign s = sync_2[i];

        always_ff @(posedge CLOCK or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q <= INIT_LO;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise    = 1'b0;
            unique case (state_q)
                INIT_LO: begin
                    if (s) begin
                        state_d = INIT_WAIT_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = LOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                INIT_WAIT_HI: begin
                    if (!s) begin
                        state_d = INIT_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = INIT_HI;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                INIT_HI, HIGH: begin
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = '0;
                    end
                end
                LOW: begin
                    if (s) begin
                        state_d = WAIT_HI;
                        cnt_d   = '0;
                    end
                end
                // Only this path into HIGH counts as a genuine press.
                WAIT_HI: begin
                    if (!s) begin
                        state_d = LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HIGH;
                        rise    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_d = HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = LOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = INIT_LO;
                    cnt_d   = '0;
                end
            endcase
        end

        assign rise_done[i] = rise;
        assign DB_LEVEL[i]  = (state_q == INIT_HI) || (state_q == HIGH) || (state_q == WAIT_LO);
    end

    // A new press in the same cycle as TICK survives the clear.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            press_q <= '0;
        end else begin
            press_q <= (press_q & ~{N_SW{TICK}}) | rise_done;
        end
    end

    assign PRESS     = press_q;
    assign ANY_PRESS = |press_q;

endmodule

// File: tb/tb_switch_press_conditioner.sv
// Directed bench for switch_press_conditioner with a short debounce window (8 samples).
module tb_switch_press_conditioner;

    logic       CLOCK;
    logic       RESET_N;
    logic [3:0] SWITCHES;
    logic       TICK;
    logic [3:0] PRESS;
    logic [3:0] DB_LEVEL;
    logic       ANY_PRESS;

    int total;
    int bad;

    switch_press_conditioner #(
        .N_SW(4),
        .DB_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .CLOCK(CLOCK),
        .RESET_N(RESET_N),
        .SWITCHES(SWITCHES),
        .TICK(TICK),
        .PRESS(PRESS),
        .DB_LEVEL(DB_LEVEL),
        .ANY_PRESS(ANY_PRESS)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    // Holds reset for two edges with the given switch levels, releasing just after an edge.
    task automatic do_reset(input logic [3:0] sw);
        RESET_N  = 1'b0;
        SWITCHES = sw;
        TICK     = 1'b0;
        step(2);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N  = 1'b0;
        SWITCHES = 4'b0000;
        TICK     = 1'b0;
        #3;
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL reset_press: got %b want %b", PRESS, 4'b0000); end
        total++;
        if (DB_LEVEL !== 4'b0000) begin bad++; $display("[TB] FAIL reset_db: got %b want %b", DB_LEVEL, 4'b0000); end
        total++;
        if (ANY_PRESS !== 1'b0) begin bad++; $display("[TB] FAIL reset_any: got %b want %b", ANY_PRESS, 1'b0); end
    endtask

    task automatic test_basic_press();
        do_reset(4'b0000);
        step(12);
        SWITCHES = 4'b0001;
        step(10);
        total++;
        if (DB_LEVEL !== 4'b0000) begin bad++; $display("[TB] FAIL basic_db_early: got %b want %b", DB_LEVEL, 4'b0000); end
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL basic_press_early: got %b want %b", PRESS, 4'b0000); end
        step(1);
        total++;
        if (DB_LEVEL !== 4'b0001) begin bad++; $display("[TB] FAIL basic_db_rise: got %b want %b", DB_LEVEL, 4'b0001); end
        total++;
        if (PRESS !== 4'b0001) begin bad++; $display("[TB] FAIL basic_press_rise: got %b want %b", PRESS, 4'b0001); end
        total++;
        if (ANY_PRESS !== 1'b1) begin bad++; $display("[TB] FAIL basic_any: got %b want %b", ANY_PRESS, 1'b1); end
        step(8);
        total++;
        if (PRESS !== 4'b0001) begin bad++; $display("[TB] FAIL basic_press_held: got %b want %b", PRESS, 4'b0001); end
        TICK = 1'b1;
        step(1);
        TICK = 1'b0;
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL basic_consume: got %b want %b", PRESS, 4'b0000); end
        total++;
        if (DB_LEVEL !== 4'b0001) begin bad++; $display("[TB] FAIL basic_db_kept: got %b want %b", DB_LEVEL, 4'b0001); end
    endtask

    task automatic test_bounce();
        logic [3:0] pattern [4];
        pattern = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
        do_reset(4'b0000);
        step(12);
        for (int p = 0; p < 4; p++) begin
            SWITCHES = pattern[p];
            for (int c = 0; c < 3; c++) begin
                step(1);
                total++;
                if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL bounce_no_pulse: got %b want %b", PRESS, 4'b0000); end
            end
        end
        SWITCHES = 4'b0010;
        step(10);
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL bounce_press_early: got %b want %b", PRESS, 4'b0000); end
        step(1);
        total++;
        if (PRESS !== 4'b0010) begin bad++; $display("[TB] FAIL bounce_press_rise: got %b want %b", PRESS, 4'b0010); end
    endtask

    task automatic test_tick_consume();
        do_reset(4'b0000);
        step(12);
        SWITCHES = 4'b0100;
        step(11);
        total++;
        if (PRESS !== 4'b0100) begin bad++; $display("[TB] FAIL tick_pending: got %b want %b", PRESS, 4'b0100); end
        TICK = 1'b1;
        step(1);
        TICK = 1'b0;
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL tick_clear: got %b want %b", PRESS, 4'b0000); end
        total++;
        if (ANY_PRESS !== 1'b0) begin bad++; $display("[TB] FAIL tick_any_clear: got %b want %b", ANY_PRESS, 1'b0); end
        step(2);
        TICK = 1'b1;
        step(1);
        TICK = 1'b0;
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL tick_idle_press: got %b want %b", PRESS, 4'b0000); end
        total++;
        if (DB_LEVEL !== 4'b0100) begin bad++; $display("[TB] FAIL tick_idle_db: got %b want %b", DB_LEVEL, 4'b0100); end
    endtask

    task automatic test_back_to_back();
        do_reset(4'b0000);
        step(12);
        SWITCHES = 4'b0001;
        step(11);
        total++;
        if (PRESS !== 4'b0001) begin bad++; $display("[TB] FAIL b2b_first: got %b want %b", PRESS, 4'b0001); end
        SWITCHES = 4'b1001;
        step(10);
        TICK = 1'b1;
        step(1);
        TICK = 1'b0;
        total++;
        if (PRESS !== 4'b1000) begin bad++; $display("[TB] FAIL b2b_press: got %b want %b", PRESS, 4'b1000); end
        total++;
        if (DB_LEVEL !== 4'b1001) begin bad++; $display("[TB] FAIL b2b_db: got %b want %b", DB_LEVEL, 4'b1001); end
    endtask

    task automatic test_init_high();
        do_reset(4'b1000);
        step(10);
        total++;
        if (DB_LEVEL !== 4'b0000) begin bad++; $display("[TB] FAIL init_db_early: got %b want %b", DB_LEVEL, 4'b0000); end
        step(1);
        total++;
        if (DB_LEVEL !== 4'b1000) begin bad++; $display("[TB] FAIL init_db_rise: got %b want %b", DB_LEVEL, 4'b1000); end
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL init_no_press: got %b want %b", PRESS, 4'b0000); end
        SWITCHES = 4'b0000;
        step(10);
        SWITCHES = 4'b1000;
        step(1);
        total++;
        if (DB_LEVEL !== 4'b0000) begin bad++; $display("[TB] FAIL init_db_low: got %b want %b", DB_LEVEL, 4'b0000); end
        step(9);
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL init_press_early: got %b want %b", PRESS, 4'b0000); end
        step(1);
        total++;
        if (PRESS !== 4'b1000) begin bad++; $display("[TB] FAIL init_press_rise: got %b want %b", PRESS, 4'b1000); end
    endtask

    task automatic test_async_reset();
        do_reset(4'b0000);
        step(12);
        SWITCHES = 4'b0110;
        step(11);
        total++;
        if (PRESS !== 4'b0110) begin bad++; $display("[TB] FAIL async_pending: got %b want %b", PRESS, 4'b0110); end
        SWITCHES = 4'b0111;
        step(4);
        #2;
        RESET_N = 1'b0;
        #1;
        total++;
        if (PRESS !== 4'b0000) begin bad++; $display("[TB] FAIL async_press: got %b want %b", PRESS, 4'b0000); end
        total++;
        if (DB_LEVEL !== 4'b0000) begin bad++; $display("[TB] FAIL async_db: got %b want %b", DB_LEVEL, 4'b0000); end
        total++;
        if (ANY_PRESS !== 1'b0) begin bad++; $display("[TB] FAIL async_any: got %b want %b", ANY_PRESS, 1'b0); end
        SWITCHES = 4'b0000;
        step(2);
        RESET_N = 1'b1;
        step(12);
        SWITCHES = 4'b0001;
        step(5);
        SWITCHES = 4'b0000;
        for (int c = 0; c < 15; c++) begin
            step(1);
            total++;
            if ({PRESS, DB_LEVEL} !== 8'h00) begin bad++; $display("[TB] FAIL async_short_pulse: got %b want %b", {PRESS, DB_LEVEL}, 8'h00); end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        RESET_N  = 1'b0;
        SWITCHES = 4'b0000;
        TICK     = 1'b0;
        #1;
        test_reset();
        test_basic_press();
        test_bounce();
        test_tick_consume();
        test_back_to_back();
        test_init_high();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
